// File: rtl/input_conditioner_pkg.sv
// input_cond_pkg: shared types and helpers for the input conditioner.
//   cond_state_t : per-channel debounce FSM state
//   cnt_width()  : counter width able to hold 0..max_val (at least 1 bit)
//   max_int()    : larger of two integers, used when sizing the repeat counter
// Optional feature macro used by the design: INPUT_COND_REPEAT_EN.
package input_cond_pkg;

    typedef enum logic [1:0] {
        RELEASED  = 2'd0,
        ARMING    = 2'd1,
        PRESSED   = 2'd2,
        DISARMING = 2'd3
    } cond_state_t;

    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/input_conditioner_if.sv
// input_conditioner_if: pin-side and game-logic-side signals of the conditioner.
//   raw       : asynchronous pin inputs (driven by the master)
//   level     : debounced, normalised state, 1 = pressed
//   rise/fall : one-cycle pulses on accepted press/release
//   press     : one-cycle pulse on rise, plus hold-to-repeat pulses when
//               INPUT_COND_REPEAT_EN is defined
//   state_dbg : per-channel FSM state, 2 bits per channel (channel i at [2i+:2])
// Handshake: there is none; raw is a free-running level, the outputs are
// registered levels/pulses valid on every clock, and no ready/back-pressure exists.
interface input_conditioner_if #(
    parameter int CHANNELS = 5
);
    logic [CHANNELS-1:0]   raw;
    logic [CHANNELS-1:0]   level;
    logic [CHANNELS-1:0]   rise;
    logic [CHANNELS-1:0]   fall;
    logic [CHANNELS-1:0]   press;
    logic [2*CHANNELS-1:0] state_dbg;

    modport master (
        output raw,
        input  level, rise, fall, press, state_dbg
    );

    modport slave (
        input  raw,
        output level, rise, fall, press, state_dbg
    );
endinterface

// File: rtl/input_conditioner_debounce_channel.sv
// debounce_channel: one push-button channel.
//   Polarity-normalises raw, synchronises it through two flops, debounces it
//   with a four-state FSM and produces registered level/rise/fall/press.
// Ports:
//   clk, reset (sync, active high), raw (async pin)
//   level, rise, fall, press (registered outputs), state (FSM debug)
// Macro: INPUT_COND_REPEAT_EN adds the hold-to-repeat counter on press.
module debounce_channel
    import input_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        raw,
    output logic        level,
    output logic        rise,
    output logic        fall,
    output logic        press,
    output cond_state_t state
);

    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("debounce_channel: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    localparam int               CNT_W   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             sync_q1;
    logic             sync_q2;
    logic [CNT_W-1:0] cnt;

`ifdef INPUT_COND_REPEAT_EN
    localparam int               RPT_W     = cnt_width(max_int(REPEAT_DELAY, REPEAT_PERIOD));
    localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_PERIOD - 1);
    localparam logic [RPT_W-1:0] RPT_ONE   = RPT_W'(1);

    logic [RPT_W-1:0] rpt_cnt;
    logic             rpt_periodic;  // first repeat already issued
    logic             rpt_due;
    logic             held_stay;     // channel remains held after this edge

    always_comb begin
        rpt_due   = rpt_periodic ? (rpt_cnt == RPT_NEXT) : (rpt_cnt == RPT_FIRST);
        // The release-accept edge is excluded so no press lands on the fall cycle.
        held_stay = (state == PRESSED) ||
                    ((state == DISARMING) && (sync_q2 || (cnt != CNT_MAX)));
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            state   <= RELEASED;
            cnt     <= '0;
            level   <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
            press   <= 1'b0;
`ifdef INPUT_COND_REPEAT_EN
            rpt_cnt      <= '0;
            rpt_periodic <= 1'b0;
`endif
        end else begin
            sync_q1 <= raw ^ ACTIVE_LOW;
            sync_q2 <= sync_q1;
            rise    <= 1'b0;
            fall    <= 1'b0;
            press   <= 1'b0;

            case (state)
                RELEASED: begin
                    if (sync_q2) begin
                        state <= ARMING;
                        cnt   <= CNT_ONE;
                    end
                end
                ARMING: begin
                    if (!sync_q2) begin
                        state <= RELEASED;
                        cnt   <= '0;
                    end else if (cnt == CNT_MAX) begin
                        state <= PRESSED;
                        cnt   <= '0;
                        level <= 1'b1;
                        rise  <= 1'b1;
                        press <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                PRESSED: begin
                    if (!sync_q2) begin
                        state <= DISARMING;
                        cnt   <= CNT_ONE;
                    end
                end
                DISARMING: begin
                    if (sync_q2) begin
                        // Bounce back to held: silent, repeat timing continues.
                        state <= PRESSED;
                        cnt   <= '0;
                    end else if (cnt == CNT_MAX) begin
                        state <= RELEASED;
                        cnt   <= '0;
                        level <= 1'b0;
                        fall  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= RELEASED;
                    cnt   <= '0;
                end
            endcase

`ifdef INPUT_COND_REPEAT_EN
            if (held_stay) begin
                if (rpt_due) begin
                    press        <= 1'b1;
                    rpt_cnt      <= '0;
                    rpt_periodic <= 1'b1;
                end else begin
                    rpt_cnt <= rpt_cnt + RPT_ONE;
                end
            end else begin
                // Cleared while released/arming, so the rise edge starts from zero.
                rpt_cnt      <= '0;
                rpt_periodic <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: multi-channel push-button conditioner (top).
//   One debounce_channel per input; each channel is independent.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high reset
//   bus   : input_conditioner_if.slave (raw in; level/rise/fall/press/state_dbg out)
// Macro: INPUT_COND_REPEAT_EN enables hold-to-repeat press pulses; without it
// press equals rise and the REPEAT_* parameters have no effect on behaviour.
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int                  CHANNELS        = 5,
    parameter int                  DEBOUNCE_CYCLES = 500000,
    parameter int                  REPEAT_DELAY    = 25000000,
    parameter int                  REPEAT_PERIOD   = 5000000,
    parameter logic [CHANNELS-1:0] ACTIVE_LOW      = '0
) (
    input logic                clk,
    input logic                reset,
    input_conditioner_if.slave bus
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        cond_state_t ch_state;

        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .ACTIVE_LOW      (ACTIVE_LOW[i])
        ) u_ch (
            .clk   (clk),
            .reset (reset),
            .raw   (bus.raw[i]),
            .level (bus.level[i]),
            .rise  (bus.rise[i]),
            .fall  (bus.fall[i]),
            .press (bus.press[i]),
            .state (ch_state)
        );

        assign bus.state_dbg[2*i +: 2] = ch_state;
    end

endmodule

// File: tb/tb_input_conditioner.sv
module tb_input_conditioner;

    localparam int         CH = 3;
    localparam int         DB = 4;
    localparam int         RD = 10;
    localparam int         RP = 3;
    localparam logic [2:0] AL = 3'b100;

`ifdef INPUT_COND_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    input_conditioner_if #(.CHANNELS(CH)) bus ();

    input_conditioner #(
        .CHANNELS        (CH),
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP),
        .ACTIVE_LOW      (AL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Per-cycle output log, index 0 = first edge after the stimulus change.
    logic [CH-1:0] lv_log[64];
    logic [CH-1:0] rs_log[64];
    logic [CH-1:0] fl_log[64];
    logic [CH-1:0] pr_log[64];
    int            n_log;

    // ---------------- driver tasks ----------------
    task automatic step_log();
        @(posedge clk);
        #1;
        if (n_log < 64) begin
            lv_log[n_log] = bus.level;
            rs_log[n_log] = bus.rise;
            fl_log[n_log] = bus.fall;
            pr_log[n_log] = bus.press;
        end
        n_log++;
    endtask

    task automatic drive_and_run(input logic [CH-1:0] v, input int n);
        bus.raw = v;
        n_log   = 0;
        repeat (n) step_log();
    endtask

    task automatic settle(input int n);
        bus.raw = AL;  // every channel released
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset   = 1'b1;
        bus.raw = 3'b100;
        n_log   = 0;
        repeat (20) step_log();
        for (int i = 0; i < 20; i++) begin
            checks++;
            if ({lv_log[i], rs_log[i], fl_log[i], pr_log[i]} !== 12'b0) begin
                errors++;
                $display("FAIL reset_quiet idx=%0d got lv=%b rs=%b fl=%b pr=%b, want all 0",
                         i, lv_log[i], rs_log[i], fl_log[i], pr_log[i]);
            end
        end
        checks++;
        if (bus.state_dbg !== 6'b0) begin
            errors++;
            $display("FAIL reset_state got=%b want=000000", bus.state_dbg);
        end
        reset = 1'b0;
        n_log = 0;
        repeat (20) step_log();
        for (int i = 0; i < 20; i++) begin
            checks++;
            if ({lv_log[i], rs_log[i], fl_log[i], pr_log[i]} !== 12'b0) begin
                errors++;
                $display("FAIL post_reset_quiet idx=%0d got lv=%b rs=%b fl=%b pr=%b, want all 0",
                         i, lv_log[i], rs_log[i], fl_log[i], pr_log[i]);
            end
        end
    endtask

    task automatic test_press_release();
        logic [CH-1:0] e_lv, e_rs, e_fl, e_pr;
        drive_and_run(3'b101, 8);
        for (int i = 0; i < 8; i++) begin
            e_lv = (i >= 6) ? 3'b001 : 3'b000;
            e_rs = (i == 6) ? 3'b001 : 3'b000;
            e_fl = 3'b000;
            e_pr = e_rs;
            checks++;
            if ({lv_log[i], rs_log[i], fl_log[i], pr_log[i]} !== {e_lv, e_rs, e_fl, e_pr}) begin
                errors++;
                $display("FAIL press idx=%0d got lv=%b rs=%b fl=%b pr=%b want lv=%b rs=%b fl=%b pr=%b",
                         i, lv_log[i], rs_log[i], fl_log[i], pr_log[i], e_lv, e_rs, e_fl, e_pr);
            end
        end
        drive_and_run(3'b100, 12);
        for (int i = 0; i < 12; i++) begin
            e_lv = (i < 6) ? 3'b001 : 3'b000;
            e_rs = 3'b000;
            e_fl = (i == 6) ? 3'b001 : 3'b000;
            e_pr = 3'b000;
            checks++;
            if ({lv_log[i], rs_log[i], fl_log[i], pr_log[i]} !== {e_lv, e_rs, e_fl, e_pr}) begin
                errors++;
                $display("FAIL release idx=%0d got lv=%b rs=%b fl=%b pr=%b want lv=%b rs=%b fl=%b pr=%b",
                         i, lv_log[i], rs_log[i], fl_log[i], pr_log[i], e_lv, e_rs, e_fl, e_pr);
            end
        end
    endtask

    task automatic test_glitch();
        n_log = 0;
        for (int r = 0; r < 4; r++) begin
            bus.raw = 3'b110;  // raw[1] high for 3 cycles
            repeat (3) step_log();
            bus.raw = 3'b100;
            repeat (2) step_log();
        end
        repeat (8) step_log();
        for (int i = 0; i < 28; i++) begin
            checks++;
            if ({lv_log[i], rs_log[i], fl_log[i], pr_log[i]} !== 12'b0) begin
                errors++;
                $display("FAIL glitch idx=%0d got lv=%b rs=%b fl=%b pr=%b, want all 0",
                         i, lv_log[i], rs_log[i], fl_log[i], pr_log[i]);
            end
        end
    endtask

    task automatic test_repeat();
        logic [CH-1:0] e_lv, e_rs, e_fl, e_pr;
        drive_and_run(3'b101, 40);
        for (int i = 0; i < 40; i++) begin
            e_lv = (i >= 6) ? 3'b001 : 3'b000;
            e_rs = (i == 6) ? 3'b001 : 3'b000;
            e_fl = 3'b000;
            // Rise at idx 6; repeats at rise+10 (idx 16) then every 3 cycles.
            e_pr = ((i == 6) || (REP_EN && i >= 16 && ((i - 16) % 3) == 0)) ? 3'b001 : 3'b000;
            checks++;
            if ({lv_log[i], rs_log[i], fl_log[i], pr_log[i]} !== {e_lv, e_rs, e_fl, e_pr}) begin
                errors++;
                $display("FAIL repeat_hold idx=%0d got lv=%b rs=%b fl=%b pr=%b want lv=%b rs=%b fl=%b pr=%b",
                         i, lv_log[i], rs_log[i], fl_log[i], pr_log[i], e_lv, e_rs, e_fl, e_pr);
            end
        end
        // Release run idx 0 = rise+34: repeat at rise+37 (idx 3) still held;
        // rise+40 coincides with the fall cycle and must not pulse press.
        drive_and_run(3'b100, 12);
        for (int i = 0; i < 12; i++) begin
            e_lv = (i < 6) ? 3'b001 : 3'b000;
            e_rs = 3'b000;
            e_fl = (i == 6) ? 3'b001 : 3'b000;
            e_pr = (REP_EN && i == 3) ? 3'b001 : 3'b000;
            checks++;
            if ({lv_log[i], rs_log[i], fl_log[i], pr_log[i]} !== {e_lv, e_rs, e_fl, e_pr}) begin
                errors++;
                $display("FAIL repeat_release idx=%0d got lv=%b rs=%b fl=%b pr=%b want lv=%b rs=%b fl=%b pr=%b",
                         i, lv_log[i], rs_log[i], fl_log[i], pr_log[i], e_lv, e_rs, e_fl, e_pr);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [CH-1:0] e_lv, e_rs, e_fl, e_pr;
        drive_and_run(3'b001, 10);  // raw[0] high, raw[2] low (active-low press)
        for (int i = 0; i < 10; i++) begin
            e_lv = (i >= 6) ? 3'b101 : 3'b000;
            e_rs = (i == 6) ? 3'b101 : 3'b000;
            e_fl = 3'b000;
            e_pr = e_rs;
            checks++;
            if ({lv_log[i], rs_log[i], fl_log[i], pr_log[i]} !== {e_lv, e_rs, e_fl, e_pr}) begin
                errors++;
                $display("FAIL simul_press idx=%0d got lv=%b rs=%b fl=%b pr=%b want lv=%b rs=%b fl=%b pr=%b",
                         i, lv_log[i], rs_log[i], fl_log[i], pr_log[i], e_lv, e_rs, e_fl, e_pr);
            end
        end
        // Fall lands exactly at rise+10, where a first repeat would otherwise be due.
        drive_and_run(3'b100, 10);
        for (int i = 0; i < 10; i++) begin
            e_lv = (i < 6) ? 3'b101 : 3'b000;
            e_rs = 3'b000;
            e_fl = (i == 6) ? 3'b101 : 3'b000;
            e_pr = 3'b000;
            checks++;
            if ({lv_log[i], rs_log[i], fl_log[i], pr_log[i]} !== {e_lv, e_rs, e_fl, e_pr}) begin
                errors++;
                $display("FAIL simul_release idx=%0d got lv=%b rs=%b fl=%b pr=%b want lv=%b rs=%b fl=%b pr=%b",
                         i, lv_log[i], rs_log[i], fl_log[i], pr_log[i], e_lv, e_rs, e_fl, e_pr);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [CH-1:0] e_lv, e_rs, e_pr;
        drive_and_run(3'b101, 5);  // idx 4: channel 0 is ARMING with cnt=3
        checks++;
        if (bus.state_dbg[1:0] !== 2'd1) begin
            errors++;
            $display("FAIL mid_arming_state got=%0d want=1", bus.state_dbg[1:0]);
        end
        reset = 1'b1;
        step_log();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if ({lv_log[i], rs_log[i], fl_log[i], pr_log[i]} !== 12'b0) begin
                errors++;
                $display("FAIL mid_reset_quiet idx=%0d got lv=%b rs=%b fl=%b pr=%b, want all 0",
                         i, lv_log[i], rs_log[i], fl_log[i], pr_log[i]);
            end
        end
        // raw still held: first post-reset sample is the next edge (idx 0).
        n_log = 0;
        repeat (10) step_log();
        for (int i = 0; i < 10; i++) begin
            e_lv = (i >= 6) ? 3'b001 : 3'b000;
            e_rs = (i == 6) ? 3'b001 : 3'b000;
            e_pr = e_rs;
            checks++;
            if ({lv_log[i], rs_log[i], fl_log[i], pr_log[i]} !== {e_lv, e_rs, 3'b000, e_pr}) begin
                errors++;
                $display("FAIL after_reset idx=%0d got lv=%b rs=%b fl=%b pr=%b want lv=%b rs=%b fl=000 pr=%b",
                         i, lv_log[i], rs_log[i], fl_log[i], pr_log[i], e_lv, e_rs, e_pr);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset   = 1'b1;
        bus.raw = 3'b100;
        n_log   = 0;
        test_reset();
        test_press_release();
        settle(4);
        test_glitch();
        settle(4);
        test_repeat();
        settle(4);
        test_simultaneous();
        settle(4);
        test_reset_mid();
        settle(15);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
